// File: rtl/owm_slave_pkg.sv
// Shared 1-Wire definitions: slave FSM encoding and the default timing set
// (ticks of 1 us) that master and slave both build on.
package owm_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLOT,
        ST_HOLD,
        ST_PDH,
        ST_PDL
    } owm_state_t;

    localparam int OWM_DIV   = 50;
    localparam int OWM_TW    = 10;
    localparam int OWM_T_SMP = 30;
    localparam int OWM_T_RD  = 30;
    localparam int OWM_T_RST = 480;
    localparam int OWM_T_PDH = 30;
    localparam int OWM_T_PDL = 120;

endpackage

// File: rtl/owm_tick_timer.sv
// 1 us prescaler feeding a saturating slot timer; clr restarts both so that
// tick n after a clear lands exactly n*DIV cycles later.
module owm_tick_timer
    import owm_slave_pkg::*;
#(
    parameter int DIV = OWM_DIV,
    parameter int TW  = OWM_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ena,
    output logic          tick,
    output logic [TW-1:0] t
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre;

    assign tick = ena && (pre == PW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            t   <= '0;
        end else if (clr) begin
            pre <= '0;
            t   <= '0;
        end else if (ena) begin
            if (tick) begin
                pre <= '0;
                if (t != '1) t <= t + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/owm_slave.sv
// Bit-level 1-Wire responder: decodes master slots and resets, drives
// read-slot zeros and presence pulses through an open-drain enable.
module owm_slave
    import owm_slave_pkg::*;
#(
    parameter int DIV   = OWM_DIV,
    parameter int TW    = OWM_TW,
    parameter int T_SMP = OWM_T_SMP,
    parameter int T_RD  = OWM_T_RD,
    parameter int T_RST = OWM_T_RST,
    parameter int T_PDH = OWM_T_PDH,
    parameter int T_PDL = OWM_T_PDL
) (
    input  logic clk,
    input  logic rst,
    input  logic owr_i,
    output logic owr_e,
    input  logic tx_dat,
    input  logic tx_vld,
    output logic tx_rdy,
    output logic rx_dat,
    output logic rx_vld,
    output logic rst_det
);
    logic owr_m, owr_s, owr_p, fall;

    // NOTE: state flops take non-blocking assignments so every register
    // samples pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owr_m <= 1'b1;
            owr_s <= 1'b1;
            owr_p <= 1'b1;
        end else begin
            owr_m <= owr_i;
            owr_s <= owr_m;
            owr_p <= owr_s;
        end
    end

    assign fall = owr_p & ~owr_s;

    owm_state_t    state, state_nxt;
    logic          tick, clr, ena;
    logic [TW-1:0] t;
    logic          tx_taken;

    assign ena = (state != ST_IDLE);

    owm_tick_timer #(.DIV(DIV), .TW(TW)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .ena  (ena),
        .tick (tick),
        .t    (t)
    );

    // hit_x is true in the cycle whose tick carries t up to x, so the
    // registered response appears exactly x*DIV cycles after the clear.
    logic hit_rd, hit_smp, hit_rst, hit_pdh, hit_pdl, past_rst;
    assign hit_rd   = tick && (t == TW'(T_RD - 1));
    assign hit_smp  = tick && (t == TW'(T_SMP - 1));
    assign hit_rst  = tick && (t == TW'(T_RST - 1));
    assign hit_pdh  = tick && (t == TW'(T_PDH - 1));
    assign hit_pdl  = tick && (t == TW'(T_PDL - 1));
    assign past_rst = (t >= TW'(T_RST));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (fall)    state_nxt = ST_SLOT;
            ST_SLOT: if (hit_smp) state_nxt = ST_HOLD;
            ST_HOLD: if (owr_s)   state_nxt = past_rst ? ST_PDH : ST_IDLE;
            ST_PDH:  if (hit_pdh) state_nxt = ST_PDL;
            ST_PDL:  if (hit_pdl) state_nxt = ST_IDLE;
            default:              state_nxt = ST_IDLE;
        endcase
    end

    logic owr_e_nxt, tx_rdy_nxt, rx_dat_nxt, rx_vld_nxt, rst_det_nxt, tx_taken_nxt;

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        owr_e_nxt    = 1'b0;
        tx_rdy_nxt   = 1'b0;
        rx_dat_nxt   = rx_dat;
        rx_vld_nxt   = 1'b0;
        rst_det_nxt  = 1'b0;
        tx_taken_nxt = tx_taken & tx_vld;
        clr          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    clr = 1'b1;
                    if (tx_vld && !tx_taken) begin
                        tx_rdy_nxt   = 1'b1;
                        tx_taken_nxt = 1'b1;
                        owr_e_nxt    = ~tx_dat;
                    end
                end
            end
            ST_SLOT: begin
                owr_e_nxt = owr_e & ~hit_rd;
                if (hit_smp) begin
                    rx_vld_nxt = 1'b1;
                    rx_dat_nxt = owr_s;
                end
            end
            ST_HOLD: begin
                if (!owr_s && hit_rst) rst_det_nxt = 1'b1;
                if (owr_s && past_rst) clr = 1'b1;
            end
            ST_PDH: begin
                if (hit_pdh) begin
                    clr       = 1'b1;
                    owr_e_nxt = 1'b1;
                end
            end
            ST_PDL:  owr_e_nxt = ~hit_pdl;
            default: owr_e_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            owr_e    <= 1'b0;
            tx_rdy   <= 1'b0;
            rx_dat   <= 1'b1;
            rx_vld   <= 1'b0;
            rst_det  <= 1'b0;
            tx_taken <= 1'b0;
        end else begin
            state    <= state_nxt;
            owr_e    <= owr_e_nxt;
            tx_rdy   <= tx_rdy_nxt;
            rx_dat   <= rx_dat_nxt;
            rx_vld   <= rx_vld_nxt;
            rst_det  <= rst_det_nxt;
            tx_taken <= tx_taken_nxt;
        end
    end

endmodule

// File: tb/tb_owm_slave.sv
// Directed bench for owm_slave at DIV=4: a wired-AND bus model, a negedge
// event monitor, and hand-computed cycle offsets from the master's drive.
module tb_owm_slave;
    localparam int DIV = 4;
    // master drive -> sync (2) -> edge detect (1) -> registered response
    localparam int LAT = 3;

    logic clk = 1'b0, rst = 1'b1, m_low = 1'b0, tx_dat = 1'b0, tx_vld = 1'b0;
    logic owr_i, owr_e, tx_rdy, rx_dat, rx_vld, rst_det;

    assign owr_i = ~(m_low | owr_e);

    always #5 clk = ~clk;

    owm_slave #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .owr_i   (owr_i),
        .owr_e   (owr_e),
        .tx_dat  (tx_dat),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .rx_dat  (rx_dat),
        .rx_vld  (rx_vld),
        .rst_det (rst_det)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tx = 0, c_tx = 0, n_rx = 0, c_rx = 0, n_rd = 0, c_rd = 0;
    int n_oe = 0, c_rise = 0, c_fall = 0;
    logic last_rx = 1'b1, oe_prev = 1'b0;

    always @(negedge clk) begin
        if (tx_rdy)  begin n_tx <= n_tx + 1; c_tx <= cyc; end
        if (rx_vld)  begin n_rx <= n_rx + 1; c_rx <= cyc; last_rx <= rx_dat; end
        if (rst_det) begin n_rd <= n_rd + 1; c_rd <= cyc; end
        if (owr_e) n_oe <= n_oe + 1;
        if (owr_e && !oe_prev) c_rise <= cyc;
        if (!owr_e && oe_prev) c_fall <= cyc;
        oe_prev <= owr_e;
    end

    int n_checks = 0, n_errors = 0;
    int b_tx, b_rx, b_rd, b_oe;
    int t0, r0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        b_tx = n_tx; b_rx = n_rx; b_rd = n_rd; b_oe = n_oe;
    endtask

    // Master pulls low for n cycles; t0/r0 are the cycle counts at fall/release.
    task automatic master_low(input int n, output int t_fall, output int t_rise);
        @(negedge clk);
        m_low  = 1'b1;
        t_fall = cyc;
        repeat (n) @(negedge clk);
        m_low  = 1'b0;
        t_rise = cyc;
    endtask

    initial begin
        wait_cyc(4);
        check("rst_owr_e",   owr_e,   0);
        check("rst_tx_rdy",  tx_rdy,  0);
        check("rst_rx_dat",  rx_dat,  1);
        check("rst_rx_vld",  rx_vld,  0);
        check("rst_rst_det", rst_det, 0);
        @(negedge clk) rst = 1'b0;

        // idle bus
        snap();
        wait_cyc(1000);
        check("idle_tx",   n_tx - b_tx, 0);
        check("idle_rx",   n_rx - b_rx, 0);
        check("idle_rd",   n_rd - b_rd, 0);
        check("idle_oe",   n_oe - b_oe, 0);
        check("idle_rdat", rx_dat, 1);

        // write-0 slot: 60 ticks low
        snap();
        master_low(60 * DIV, t0, r0);
        wait_cyc(100);
        check("w0_rx_cnt", n_rx - b_rx, 1);
        check("w0_rx_cyc", c_rx - t0, LAT + 30 * DIV);
        check("w0_rx_dat", last_rx, 0);
        check("w0_oe",     n_oe - b_oe, 0);

        // write-1 slot: 6 ticks low
        snap();
        master_low(6 * DIV, t0, r0);
        wait_cyc(200);
        check("w1_rx_cnt", n_rx - b_rx, 1);
        check("w1_rx_cyc", c_rx - t0, LAT + 30 * DIV);
        check("w1_rx_dat", last_rx, 1);

        // read slot returning 0
        tx_dat = 1'b0; tx_vld = 1'b1;
        snap();
        master_low(1 * DIV, t0, r0);
        wait_cyc(200);
        tx_vld = 1'b0;
        check("r0_tx_cnt",  n_tx - b_tx, 1);
        check("r0_tx_cyc",  c_tx - t0, LAT);
        check("r0_oe_rise", c_rise - t0, LAT);
        check("r0_oe_len",  n_oe - b_oe, 30 * DIV);
        check("r0_oe_fall", c_fall - t0, LAT + 30 * DIV);
        check("r0_rx_dat",  last_rx, 0);
        wait_cyc(10);

        // read slot returning 1
        tx_dat = 1'b1; tx_vld = 1'b1;
        snap();
        master_low(1 * DIV, t0, r0);
        wait_cyc(200);
        tx_vld = 1'b0;
        check("r1_tx_cnt", n_tx - b_tx, 1);
        check("r1_oe",     n_oe - b_oe, 0);
        check("r1_rx_cnt", n_rx - b_rx, 1);
        check("r1_rx_dat", last_rx, 1);
        wait_cyc(10);

        // bus reset 500 ticks, then presence
        snap();
        master_low(500 * DIV, t0, r0);
        wait_cyc(123 + 480 + 50);
        check("rst_det_cnt", n_rd - b_rd, 1);
        check("rst_det_cyc", c_rd - t0, LAT + 480 * DIV);
        check("pd_start",    c_rise - r0, LAT + 30 * DIV);
        check("pd_width",    c_fall - c_rise, 120 * DIV);
        check("pd_oe_cnt",   n_oe - b_oe, 120 * DIV);

        // 479 ticks is not a reset
        snap();
        master_low(479 * DIV, t0, r0);
        wait_cyc(700);
        check("short_rst_rd", n_rd - b_rd, 0);
        check("short_rst_oe", n_oe - b_oe, 0);
        check("short_rst_rx", n_rx - b_rx, 1);

        // falling edge during PDH and a master pulse during PDL are ignored
        master_low(500 * DIV, t0, r0);
        snap();
        repeat (37) @(negedge clk);
        m_low = 1'b1;
        repeat (8) @(negedge clk);
        m_low = 1'b0;
        repeat (155) @(negedge clk);
        m_low = 1'b1;
        repeat (20) @(negedge clk);
        m_low = 1'b0;
        wait_cyc(500);
        check("pd_ign_start", c_rise - r0, LAT + 30 * DIV);
        check("pd_ign_width", c_fall - c_rise, 120 * DIV);
        check("pd_ign_rx",    n_rx - b_rx, 0);
        check("pd_ign_oe",    n_oe - b_oe, 120 * DIV);

        // tx_vld held across two slots: consumed once
        tx_dat = 1'b0; tx_vld = 1'b1;
        snap();
        master_low(1 * DIV, t0, r0);
        wait_cyc(200);
        master_low(1 * DIV, t0, r0);
        wait_cyc(200);
        tx_vld = 1'b0;
        check("hold_tx_cnt", n_tx - b_tx, 1);
        check("hold_oe",     n_oe - b_oe, 30 * DIV);
        check("hold_rx_cnt", n_rx - b_rx, 2);
        check("hold_rx_dat", last_rx, 1);
        wait_cyc(10);

        // rst during presence
        master_low(500 * DIV, t0, r0);
        wait_cyc(200);
        check("pdl_drive", owr_e, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_oe",  owr_e,   0);
        check("rst_mid_rdy", tx_rdy,  0);
        check("rst_mid_vld", rx_vld,  0);
        check("rst_mid_det", rst_det, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        snap();
        wait_cyc(700);
        check("post_rst_oe", n_oe - b_oe, 0);
        snap();
        master_low(60 * DIV, t0, r0);
        wait_cyc(100);
        check("post_rst_rx_cnt", n_rx - b_rx, 1);
        check("post_rst_rx_cyc", c_rx - t0, LAT + 30 * DIV);
        check("post_rst_rx_dat", last_rx, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/owm_slave.md
# owm_slave

Bit-level 1-Wire responder: the slave-side counterpart of the team's 1-Wire master. It watches the open-drain line and detects master reset pulses, answering each with a presence pulse. In every time slot it samples the bus and reports the bit, and it drives read-slot zeros from a one-bit transmit handshake. It sits between the pad (open-drain enable) and a byte-level slave controller.

## Interface
- DIV, 50: clock cycles per 1 µs tick (≥2).
- TW, 10: slot timer width in ticks; must hold T_RST.
- T_SMP, 30: ticks after falling edge at which the bus is sampled.
- T_RD, 30: ticks the slave holds the line low for a read-slot 0 (T_RD ≤ T_SMP).
- T_RST, 480: minimum low time, in ticks, classified as bus reset.
- T_PDH, 30: ticks from the reset's rising edge to presence start.
- T_PDL, 120: presence pulse low time in ticks.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- owr_i  in  1  raw line input (asynchronous).
- owr_e  out  1  pull-down enable, 1 = drive line low.
- tx_dat  in  1  bit to return in the next read slot.
- tx_vld  in  1  tx_dat valid.
- tx_rdy  out  1  one-cycle pulse: tx bit consumed by a slot.
- rx_dat  out  1  bus value sampled at T_SMP.
- rx_vld  out  1  one-cycle pulse: rx_dat valid.
- rst_det  out  1  one-cycle pulse: bus reset recognised.

## Operation
- owr_i passes through a 2-flop synchroniser to give owr_s. A falling edge is owr_s 1→0 on consecutive cycles, and a rising edge is 0→1.
- Tick prescaler counts 0..DIV-1. It is forced to 0 on a falling edge, so tick n after the edge lands exactly n·DIV cycles later.
- Slot timer t counts ticks up from 0 at the falling edge and saturates at 2^TW-1.
- FSM states: IDLE, SLOT, HOLD, PDH, PDL.
  - IDLE→SLOT on a falling edge. In the same cycle: t cleared and tx_vld sampled. If tx_vld=1, the bit is latched, tx_rdy pulses, and drv0 = ~tx_dat.
  - SLOT: owr_e = drv0 while t < T_RD. At t == T_SMP: rx_dat = owr_s, rx_vld pulses, go to HOLD.
  - HOLD: a rising edge with t < T_RST returns to IDLE. When t reaches T_RST with the line still low: rst_det pulses, the remaining low time is waited out, and a rising edge goes to PDH.
  - PDH: the timer restarts at 0. At t == T_PDH go to PDL.
  - PDL: owr_e = 1. At t == T_PDL, release the line and go to IDLE.
- Boundary conditions:
  - Short pulse (rising edge before T_SMP): remain in SLOT. The sample still occurs at T_SMP and reads 1.
  - Falling edge during PDH or PDL is ignored. Presence always completes.
  - A reset observed in any slot discards nothing further. A tx bit already consumed is not re-offered.
  - tx_vld without a slot: the bit is held until the next falling edge. tx_dat must stay stable while tx_vld=1.
- rst asserted mid-operation: line released immediately (owr_e = 0), FSM goes to IDLE, and all pulses deassert.

## Timing
- Reset values: owr_e = 0, tx_rdy = 0, rx_dat = 1, rx_vld = 0, rst_det = 0, FSM in IDLE, synchroniser flops = 1.
- Input latency: 2 cycles for the synchroniser plus 1 cycle for edge detect. All event times are measured from the detected edge.
- owr_e is registered and asserts the cycle after the edge is detected.
- rx_vld: T_SMP·DIV cycles after the detected falling edge, ±0.
- rst_det: T_RST·DIV cycles after the detected falling edge.
- Presence: starts T_PDH·DIV cycles after the detected rising edge and lasts exactly T_PDL·DIV cycles.
- tx_rdy, rx_vld and rst_det are each exactly 1 cycle wide.

## Structure
- Shared package/include owm_slave_pkg: FSM state encoding and the default timing constants. The master reuses the same constant set.
- One sub-module, owm_tick_timer, holds the prescaler and the saturating TW-bit up-counter. It has clr and ena inputs and outputs tick and t.
- The FSM, synchroniser and output registers live in owm_slave.

## Test plan
All scenarios use DIV=4.
- After rst, hold the line high 1000 cycles → owr_e=0, no pulses, rx_dat=1.
- Write-0 slot: low 60 ticks → rx_vld at tick 30 with rx_dat=0. Write-1 slot: low 6 ticks → rx_vld with rx_dat=1.
- Read slot with tx_vld=1, tx_dat=0: master low 1 tick → tx_rdy at the edge, owr_e=1 for 30 ticks, rx_vld with rx_dat=0. With tx_dat=1 → owr_e stays 0 and rx_dat=1.
- Reset: master low 500 ticks → rst_det at tick 480. Presence owr_e=1 starts 30 ticks after the rising edge and lasts 120 ticks. Low for 479 ticks → no rst_det.
- Falling edge injected during PDL → ignored, and presence is still 120 ticks. tx_vld held across two slots → only one tx_rdy.
- Assert rst while owr_e=1 in PDL → owr_e=0 on the next edge of rst, FSM back in IDLE, and the next write slot decodes correctly.
